// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle plus the register outputs the peripheral drives.
// The controller side (master) drives the pins. The peripheral side (slave) drives the registers.
interface spi_reg_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe
  );
endinterface

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 register peripheral. It synchronises the pins, shifts in 16-bit frames
// and commits valid writes into five 8-bit control registers on the ncs rising edge.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input logic                  clk,
  input logic                  rst,
  spi_reg_peripheral_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
  logic                   r_sclk_prev, r_ncs_prev;
  logic [15:0]            r_shift;
  logic [4:0]             r_cnt;
  logic                   r_start_pend;
  logic                   r_wr_strobe;
  logic [7:0]             r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;

  logic w_sclk, w_copi, w_ncs;
  logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
  logic w_start, w_shift_en, w_commit;
  logic [6:0] w_addr;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs & r_ncs_prev;
  assign w_ncs_rise  = w_ncs & ~r_ncs_prev;
  assign w_addr      = r_shift[14:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.ncs};
      r_sclk_prev <= w_sclk;
      r_ncs_prev  <= w_ncs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A frame start seen during COMMIT is latched in r_start_pend and acted on one cycle later.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ncs_fall || r_start_pend) begin
          w_start = 1'b1;
          w_next  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_ncs_rise) w_next = S_COMMIT;
        else if (w_sclk_rise) w_shift_en = 1'b1;
      end
      S_COMMIT: begin
        w_commit = (r_cnt == 5'd16) && r_shift[15] && (32'(w_addr) <= MAX_ADDR);
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_start_pend <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_reg0       <= '0;
      r_reg1       <= '0;
      r_reg2       <= '0;
      r_reg3       <= '0;
      r_reg4       <= '0;
    end else begin
      r_start_pend <= (r_state == S_COMMIT) && w_ncs_fall;
      r_wr_strobe  <= w_commit;
      if (w_start) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_copi};
        // The count stops at 17 so that any overlength frame fails the commit check.
        if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
      end
      if (w_commit) begin
        case (w_addr)
          7'd0:    r_reg0 <= r_shift[7:0];
          7'd1:    r_reg1 <= r_shift[7:0];
          7'd2:    r_reg2 <= r_shift[7:0];
          7'd3:    r_reg3 <= r_shift[7:0];
          7'd4:    r_reg4 <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.en_reg_out_7_0  = r_reg0;
  assign bus.en_reg_out_15_8 = r_reg1;
  assign bus.en_reg_pwm_7_0  = r_reg2;
  assign bus.en_reg_pwm_15_8 = r_reg3;
  assign bus.pwm_duty_cycle  = r_reg4;
  assign bus.wr_strobe       = r_wr_strobe;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Bench for spi_reg_peripheral. Directed and random frames drive a register model. Expected
// commits are queued and checked by a separate strobe monitor for data and latency.
module tb_spi_reg_peripheral;
  localparam int S    = 2;
  localparam int MAXA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_peripheral_if bus ();

  spi_reg_peripheral #(.SYNC_STAGES(S), .MAX_ADDR(MAXA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         t;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mregs [5];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0:       return bus.en_reg_out_7_0;
      1:       return bus.en_reg_out_15_8;
      2:       return bus.en_reg_pwm_7_0;
      3:       return bus.en_reg_pwm_15_8;
      default: return bus.pwm_duty_cycle;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each strobe cycle consumes one expected commit, so a stretched or spurious strobe is caught.
  always @(negedge clk) begin
    if (!rst && bus.wr_strobe === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=1 required=0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("strobe_data_a%0d", e.addr), 32'(dut_reg(e.addr)), 32'(e.data));
        chk("strobe_latency", 32'(cyc - e.t), 32'(S + 2));
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.sclk = 1'b0;
    wt(1);
    bus.copi = b;
    wt(1);
    bus.sclk = 1'b1;
    wt(2);
  endtask

  task automatic end_frame(input logic [31:0] word, input int nbits);
    int a;
    bus.sclk = 1'b0;
    wt(3);
    bus.ncs = 1'b1;
    a = int'(word[14:8]);
    if (nbits == 16 && word[15] && a <= MAXA) begin
      mregs[a] = word[7:0];
      q.push_back('{a, word[7:0], cyc});
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int gap);
    bus.ncs = 1'b0;
    wt(2);
    for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
    end_frame(word, nbits);
    wt(gap);
  endtask

  task automatic check_regs(input string tag);
    wt(S + 4);
    for (int a = 0; a < 5; a++)
      chk($sformatf("%s_reg%0d", tag, a), 32'(dut_reg(a)), 32'(mregs[a]));
  endtask

  // Nine bits of a valid write, a reset pulse, then the rest of the frame. The reset pulse must
  // abort the frame and clear the registers in the model too.
  task automatic midframe_reset(input string tag);
    logic [31:0] w;
    w = 32'h80F0;
    bus.ncs = 1'b0;
    wt(2);
    for (int i = 15; i >= 7; i--) send_bit(w[i]);
    bus.sclk = 1'b0;
    wt(1);
    rst = 1'b1;
    wt(2);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) mregs[a] = 8'h00;
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
    bus.sclk = 1'b0;
    wt(3);
    bus.ncs = 1'b1;
    check_regs(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int nb, r;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    for (int a = 0; a < 5; a++) mregs[a] = 8'h00;
    wt(3);
    rst = 1'b0;
    wt(1);
    for (int a = 0; a < 5; a++) chk($sformatf("rst_reg%0d", a), 32'(dut_reg(a)), 32'h0);
    chk("rst_strobe", 32'(bus.wr_strobe), 32'h0);

    midframe_reset("midrst");

    send_frame(32'h80F0, 16, 0); check_regs("w80F0");
    send_frame(32'h84C3, 16, 0); check_regs("w84C3");

    send_frame(32'h00AA, 16, 0);     check_regs("read");
    send_frame(32'h8555, 16, 0);     check_regs("addr5");
    send_frame(32'h84_11 >> 1, 15, 0); check_regs("short15");
    send_frame(32'h1_84_22, 17, 0);  check_regs("long17");

    send_frame(32'h8201, 16, 1);
    send_frame(32'h8302, 16, 0);
    check_regs("b2b");

    for (int i = 0; i < 10; i++) begin
      bus.sclk = ~bus.sclk;
      bus.copi = 1'($urandom);
      wt(2);
    end
    bus.sclk = 1'b0;
    wt(2);
    send_frame(32'h81FF, 16, 0); check_regs("glitch");

    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      w  = $urandom;
      w[15]   = ($urandom_range(0, 7) != 0);
      w[14:8] = 7'($urandom_range(0, 6));
      send_frame(w, nb, 0);
      check_regs($sformatf("rnd%0d", n));
    end

    midframe_reset("midrst2");

    wt(S + 4);
    chk("pending_commits", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
